// File: rtl/usb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_sched
// Brief    : USB device transmit scheduler. Arbitrates handshake and data
//            packets, enforces inter-packet gap / turnaround, handshake timeout.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_sched #(
   parameter int DW    = 8,
   parameter int GAP_W = 6,
   parameter int TO_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [GAP_W-1:0] delay_threshole,
   input  logic [TO_W-1:0]  time_threshold,
   input  logic             rx_done,
   input  logic             rx_pid_en,
   input  logic             hs_valid,
   input  logic [3:0]       hs_pid,
   output logic             hs_ready,
   input  logic             tx_lt_sop,
   input  logic             tx_lt_eop,
   input  logic             tx_lt_valid,
   input  logic [DW-1:0]    tx_lt_data,
   input  logic             tx_lt_cancle,
   input  logic             data_need_ack,
   output logic             tx_lt_ready,
   output logic [3:0]       tx_pid,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             tx_lp_sop,
   output logic             tx_lp_eop,
   output logic             tx_lp_valid,
   output logic [DW-1:0]    tx_lp_data,
   input  logic             tx_lp_ready,
   output logic             cancle,
   output logic             d_oe,
   output logic             time_out
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND_HS   = 3'd1,
      SEND_DATA = 3'd2,
      WAIT_ACK  = 3'd3,
      GAP       = 3'd4
   } state_t;

   localparam logic [GAP_W-1:0] C_GAP_ONE = GAP_W'(1);
   localparam logic [TO_W-1:0]  C_TO_ONE  = TO_W'(1);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_tx_pid;
   logic             r_need_ack;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [TO_W-1:0]  r_to_cnt;
   logic             w_hs_accept;
   logic             w_data_start;
   logic             w_gap_done;

   // A zero threshold still yields one GAP cycle.
   assign w_gap_done = (delay_threshole == '0) ||
                       (r_gap_cnt == (delay_threshole - C_GAP_ONE));

   always_comb begin
      w_next       = r_state;
      w_hs_accept  = 1'b0;
      w_data_start = 1'b0;
      hs_ready     = 1'b0;
      tx_lt_ready  = 1'b0;
      tx_valid     = 1'b0;
      tx_lp_sop    = 1'b0;
      tx_lp_eop    = 1'b0;
      tx_lp_valid  = 1'b0;
      tx_lp_data   = '0;
      cancle       = 1'b0;
      d_oe         = 1'b0;
      time_out     = 1'b0;
      case (r_state)
         IDLE: begin
            if (rx_done) begin
               w_next = GAP;
            end else if (hs_valid) begin
               hs_ready    = 1'b1;
               w_hs_accept = 1'b1;
               w_next      = SEND_HS;
            end else if (tx_lt_valid && tx_lt_sop) begin
               w_data_start = 1'b1;
               w_next       = SEND_DATA;
            end else if (tx_lt_valid) begin
               tx_lt_ready = 1'b1;
            end
         end
         SEND_HS: begin
            tx_valid = 1'b1;
            d_oe     = 1'b1;
            if (tx_ready) w_next = GAP;
         end
         SEND_DATA: begin
            d_oe = 1'b1;
            tx_lp_data = tx_lt_data;
            if (tx_lt_cancle) begin
               // Abort suppresses the beat entirely, including any eop.
               cancle = 1'b1;
               w_next = GAP;
            end else begin
               tx_lp_sop   = tx_lt_sop;
               tx_lp_eop   = tx_lt_eop;
               tx_lp_valid = tx_lt_valid;
               tx_lt_ready = tx_lp_ready;
               if (tx_lt_valid && tx_lp_ready && tx_lt_eop)
                  w_next = r_need_ack ? WAIT_ACK : GAP;
            end
         end
         WAIT_ACK: begin
            if (rx_pid_en) begin
               w_next = GAP;
            end else if (r_to_cnt == time_threshold) begin
               time_out = 1'b1;
               w_next   = GAP;
            end
         end
         GAP: begin
            if (!rx_done && w_gap_done) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // Reset silences every output immediately, independent of the clock.
      if (rst) begin
         hs_ready    = 1'b0;
         tx_lt_ready = 1'b0;
         tx_valid    = 1'b0;
         tx_lp_sop   = 1'b0;
         tx_lp_eop   = 1'b0;
         tx_lp_valid = 1'b0;
         tx_lp_data  = '0;
         cancle      = 1'b0;
         d_oe        = 1'b0;
         time_out    = 1'b0;
      end
   end

   assign tx_pid = r_tx_pid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_tx_pid   <= '0;
         r_need_ack <= 1'b0;
         r_gap_cnt  <= '0;
         r_to_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_hs_accept)  r_tx_pid   <= hs_pid;
         if (w_data_start) r_need_ack <= data_need_ack;
         // rx_done inside GAP restarts the turnaround window.
         if (w_next == GAP && (r_state != GAP || rx_done))
            r_gap_cnt <= '0;
         else if (r_state == GAP && r_gap_cnt != '1)
            r_gap_cnt <= r_gap_cnt + C_GAP_ONE;
         if (w_next == WAIT_ACK && r_state != WAIT_ACK)
            r_to_cnt <= '0;
         else if (r_state == WAIT_ACK && r_to_cnt != '1)
            r_to_cnt <= r_to_cnt + C_TO_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_sched
// Brief    : Directed self-checking bench for usb_tx_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_sched;

   logic       clk;
   logic       rst;
   logic [5:0] delay_threshole;
   logic [15:0] time_threshold;
   logic       rx_done, rx_pid_en;
   logic       hs_valid;
   logic [3:0] hs_pid;
   logic       hs_ready;
   logic       tx_lt_sop, tx_lt_eop, tx_lt_valid;
   logic [7:0] tx_lt_data;
   logic       tx_lt_cancle, data_need_ack, tx_lt_ready;
   logic [3:0] tx_pid;
   logic       tx_valid, tx_ready;
   logic       tx_lp_sop, tx_lp_eop, tx_lp_valid;
   logic [7:0] tx_lp_data;
   logic       tx_lp_ready, cancle, d_oe, time_out;

   int n_chk;
   int n_bad;

   usb_tx_sched #(.DW(8), .GAP_W(6), .TO_W(16)) dut (
      .clk(clk), .rst(rst),
      .delay_threshole(delay_threshole), .time_threshold(time_threshold),
      .rx_done(rx_done), .rx_pid_en(rx_pid_en),
      .hs_valid(hs_valid), .hs_pid(hs_pid), .hs_ready(hs_ready),
      .tx_lt_sop(tx_lt_sop), .tx_lt_eop(tx_lt_eop), .tx_lt_valid(tx_lt_valid),
      .tx_lt_data(tx_lt_data), .tx_lt_cancle(tx_lt_cancle),
      .data_need_ack(data_need_ack), .tx_lt_ready(tx_lt_ready),
      .tx_pid(tx_pid), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_lp_sop(tx_lp_sop), .tx_lp_eop(tx_lp_eop), .tx_lp_valid(tx_lp_valid),
      .tx_lp_data(tx_lp_data), .tx_lp_ready(tx_lp_ready),
      .cancle(cancle), .d_oe(d_oe), .time_out(time_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      rx_done = 0; rx_pid_en = 0; hs_valid = 0; hs_pid = 0;
      tx_lt_sop = 0; tx_lt_eop = 0; tx_lt_valid = 0; tx_lt_data = 0;
      tx_lt_cancle = 0; data_need_ack = 0; tx_ready = 0; tx_lp_ready = 0;
   endtask

   // Non-consuming probe: a non-sop beat is only taken (discarded) in IDLE.
   task automatic measure_gap(input string tag, input int exp);
      int n;
      n = 0;
      tx_lt_valid = 1; tx_lt_sop = 0;
      settle();
      while (!tx_lt_ready && n < 100) begin
         step();
         n++;
         settle();
      end
      tx_lt_valid = 0;
      check(tag, n, exp);
   endtask

   task automatic send3(input logic ack);
      tx_lt_valid = 1; tx_lt_sop = 1; tx_lt_eop = 0; tx_lt_data = 8'h11;
      data_need_ack = ack; tx_lp_ready = 1;
      step();
      data_need_ack = 0;
      step();
      tx_lt_sop = 0; tx_lt_data = 8'h22;
      step();
      tx_lt_data = 8'h33; tx_lt_eop = 1;
      step();
      tx_lt_valid = 0; tx_lt_eop = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int n;
      int early;
      n_chk = 0; n_bad = 0;
      clk = 0; rst = 1;
      clear_inputs();
      delay_threshole = 6'd4; time_threshold = 16'd10;
      hs_valid = 1; tx_lt_valid = 1; tx_lt_sop = 1;
      #3;
      check("rst_hs_ready", hs_ready, 0);
      check("rst_lt_ready", tx_lt_ready, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_pid", tx_pid, 0);
      check("rst_d_oe", d_oe, 0);
      check("rst_lp_valid", tx_lp_valid, 0);
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // handshake with one stall cycle on tx_ready
      hs_valid = 1; hs_pid = 4'hA;
      settle();
      check("t1_hs_ready", hs_ready, 1);
      check("t1_idle_doe", d_oe, 0);
      step();
      hs_valid = 0; tx_ready = 0;
      settle();
      check("t1_tx_valid_a", tx_valid, 1);
      check("t1_tx_pid", tx_pid, 4'hA);
      check("t1_doe", d_oe, 1);
      check("t1_hs_ready_pulse", hs_ready, 0);
      step();
      tx_ready = 1;
      settle();
      check("t1_tx_valid_b", tx_valid, 1);
      step();
      tx_ready = 0;
      settle();
      check("t1_gap_doe", d_oe, 0);
      check("t1_gap_tx_valid", tx_valid, 0);
      measure_gap("t1_gap_len", 4);

      // simultaneous handshake and data sop
      hs_valid = 1; hs_pid = 4'h2;
      tx_lt_valid = 1; tx_lt_sop = 1; tx_lt_eop = 1; tx_lt_data = 8'h55;
      tx_lp_ready = 1;
      settle();
      check("t2_hs_first", hs_ready, 1);
      check("t2_lt_held", tx_lt_ready, 0);
      step();
      hs_valid = 0; tx_ready = 1;
      settle();
      check("t2_tx_valid", tx_valid, 1);
      check("t2_tx_pid", tx_pid, 4'h2);
      check("t2_lp_idle", tx_lp_valid, 0);
      step();
      tx_ready = 0;
      n = 0; early = 0;
      settle();
      while (!tx_lp_valid && n < 100) begin
         if (tx_lt_ready) early++;
         step();
         n++;
         settle();
      end
      check("t2_data_wait", n, 5);
      check("t2_early_ready", early, 0);
      check("t2_lp_sop", tx_lp_sop, 1);
      check("t2_lp_data", tx_lp_data, 8'h55);
      check("t2_lt_ready", tx_lt_ready, 1);
      step();
      clear_inputs();
      measure_gap("t2_gap_len", 4);

      // 3-byte packet with ack received in WAIT_ACK cycle 5
      tx_lt_valid = 1; tx_lt_sop = 1; tx_lt_data = 8'h11;
      data_need_ack = 1; tx_lp_ready = 1;
      settle();
      check("t3_sop_not_taken", tx_lt_ready, 0);
      step();
      data_need_ack = 0;
      settle();
      check("t3_b1_sop", tx_lp_sop, 1);
      check("t3_b1_data", tx_lp_data, 8'h11);
      check("t3_b1_ready", tx_lt_ready, 1);
      step();
      tx_lt_sop = 0; tx_lt_data = 8'h22; tx_lp_ready = 0;
      settle();
      check("t3_b2_data", tx_lp_data, 8'h22);
      check("t3_b2_throttle", tx_lt_ready, 0);
      step();
      tx_lp_ready = 1;
      settle();
      check("t3_b2_ready", tx_lt_ready, 1);
      step();
      tx_lt_data = 8'h33; tx_lt_eop = 1;
      settle();
      check("t3_b3_eop", tx_lp_eop, 1);
      check("t3_b3_data", tx_lp_data, 8'h33);
      step();
      tx_lt_eop = 0; tx_lt_sop = 0;
      for (int i = 1; i <= 5; i++) begin
         rx_pid_en = (i == 5);
         settle();
         check("t3_no_timeout", time_out, 0);
         check("t3_wait_hold", tx_lt_ready, 0);
         check("t3_wait_doe", d_oe, 0);
         step();
      end
      clear_inputs();
      measure_gap("t3_gap_len", 4);

      // same packet, no handshake: timeout on the 11th WAIT_ACK cycle
      send3(1);
      for (int i = 1; i <= 11; i++) begin
         settle();
         check("t4_timeout", time_out, (i == 11) ? 1 : 0);
         step();
      end
      clear_inputs();
      measure_gap("t4_gap_len", 4);

      // time_threshold=0 times out immediately
      time_threshold = 16'd0;
      send3(1);
      settle();
      check("t4_zero_timeout", time_out, 1);
      step();
      clear_inputs();
      measure_gap("t4_zero_gap", 4);
      time_threshold = 16'd10;

      // cancel on byte 2, coinciding with eop of an ack-needing packet
      tx_lt_valid = 1; tx_lt_sop = 1; tx_lt_data = 8'h01;
      data_need_ack = 1; tx_lp_ready = 1;
      step();
      data_need_ack = 0;
      settle();
      check("t5_b1_data", tx_lp_data, 8'h01);
      step();
      tx_lt_sop = 0; tx_lt_data = 8'h02; tx_lt_eop = 1; tx_lt_cancle = 1;
      settle();
      check("t5_cancle", cancle, 1);
      check("t5_lp_valid", tx_lp_valid, 0);
      check("t5_lt_ready", tx_lt_ready, 0);
      check("t5_no_eop", tx_lp_eop, 0);
      step();
      clear_inputs();
      settle();
      check("t5_cancle_pulse", cancle, 0);
      measure_gap("t5_gap_len", 4);
      delay_threshole = 6'd0;
      hs_valid = 1; hs_pid = 4'h6;
      settle();
      check("t5_next_hs", hs_ready, 1);
      step();
      hs_valid = 0; tx_ready = 1;
      step();
      tx_ready = 0;
      measure_gap("t5_gap_zero", 1);

      // rx_done turnaround, restart inside GAP
      delay_threshole = 6'd3;
      rx_done = 1; hs_valid = 1; hs_pid = 4'h5;
      settle();
      check("t6_rxdone_wins", hs_ready, 0);
      step();
      rx_done = 0;
      settle();
      check("t6_gap1_hold", hs_ready, 0);
      check("t6_gap1_doe", d_oe, 0);
      step();
      rx_done = 1;
      settle();
      check("t6_gap2_hold", hs_ready, 0);
      step();
      rx_done = 0;
      n = 0;
      settle();
      while (!hs_ready && n < 100) begin
         step();
         n++;
         settle();
      end
      check("t6_gap_rest", n, 3);
      step();
      hs_valid = 0; tx_ready = 1;
      settle();
      check("t6_tx_pid", tx_pid, 4'h5);
      step();
      tx_ready = 0;
      measure_gap("t6_gap_len", 3);

      // asynchronous reset in the middle of a data packet
      tx_lt_valid = 1; tx_lt_sop = 1; tx_lt_data = 8'h77; tx_lp_ready = 1;
      step();
      settle();
      check("t6_mid_lp_valid", tx_lp_valid, 1);
      #1 rst = 1;
      #1;
      check("t6_rst_lp_valid", tx_lp_valid, 0);
      check("t6_rst_doe", d_oe, 0);
      check("t6_rst_lt_ready", tx_lt_ready, 0);
      check("t6_rst_cancle", cancle, 0);
      check("t6_rst_tx_pid", tx_pid, 0);
      clear_inputs();
      @(posedge clk);
      #1 rst = 0;
      hs_valid = 1; hs_pid = 4'h9;
      settle();
      check("t6_post_rst_hs", hs_ready, 1);
      step();
      hs_valid = 0;
      settle();
      check("t6_post_rst_pid", tx_pid, 4'h9);
      check("t6_post_rst_valid", tx_valid, 1);
      step();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
